apple_place_ctrl: RTL and testbench

//  Sequencer for apple placement in the snake game. On a placement request it

---
 rtl/apple_place_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_apple_place_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apple_place_ctrl.sv
// Apple placement sequencer: draws LFSR candidates, rejects out-of-field, obstacle,
// current-apple and snake-body cells (by scanning the body RAM), then publishes the cell.
module apple_place_ctrl #(
    parameter int          X_MAX     = 38,
    parameter int          Y_MAX     = 28,
    parameter int          MAX_LEN   = 64,
    parameter int          MAX_TRIES = 255,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] level,
    input  logic [6:0] snake_len,
    input  logic       place_req,
    output logic       place_busy,
    output logic       place_done,
    output logic       place_fail,
    output logic       seg_rd_en,
    output logic [5:0] seg_rd_addr,
    input  logic [5:0] seg_rd_x,
    input  logic [4:0] seg_rd_y,
    output logic [5:0] apple_x,
    output logic [4:0] apple_y
);

    localparam logic [5:0] X_LIM   = 6'(X_MAX);
    localparam logic [4:0] Y_LIM   = 5'(Y_MAX);
    localparam logic [6:0] LEN_LIM = 7'(MAX_LEN);
    localparam logic [7:0] TRY_LIM = 8'(MAX_TRIES);

    typedef enum logic [2:0] {
        S_IDLE, S_DRAW, S_CHECK, S_SCAN, S_COMMIT, S_FAIL
    } state_t;

    state_t      state_q;
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic [7:0]  tries_q;
    logic [1:0]  level_q;
    logic [6:0]  len_q;
    logic [5:0]  cand_x_q;
    logic [4:0]  cand_y_q;
    logic [5:0]  apple_x_q;
    logic [4:0]  apple_y_q;
    logic        busy_q;
    logic        done_q;
    logic        fail_q;
    logic        rd_en_q;
    logic [5:0]  rd_addr_q;
    logic        cmp_valid_q;
    logic        cmp_last_q;

    logic        col_hit;
    logic        bar_hit;
    logic        obstacle;
    logic        cand_bad;
    logic        seg_hit;
    logic        rd_last;
    logic [7:0]  tries_inc;
    logic        reject_limit;

    // Galois form of x^16+x^14+x^13+x^11+1; a zero state can never escape, so reseed.
    assign lfsr_d = (lfsr_q == 16'h0000) ? SEED
                  : ({1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000));

    assign col_hit = ((cand_x_q == 6'd12 || cand_x_q == 6'd24) &&
                      cand_y_q >= 5'd4 && cand_y_q <= 5'd10) ||
                     ((cand_x_q == 6'd16 || cand_x_q == 6'd28) &&
                      cand_y_q >= 5'd18 && cand_y_q <= 5'd26);
    assign bar_hit = (cand_y_q == 5'd10 || cand_y_q == 5'd20) &&
                     ((cand_x_q >= 6'd5 && cand_x_q <= 6'd8) ||
                      (cand_x_q >= 6'd32 && cand_x_q <= 6'd35));
    assign obstacle = ((level_q == 2'd1 || level_q == 2'd2) && col_hit) ||
                      (level_q == 2'd2 && bar_hit);
    assign cand_bad = (cand_x_q == 6'd0) || (cand_x_q > X_LIM) ||
                      (cand_y_q == 5'd0) || (cand_y_q > Y_LIM) || obstacle ||
                      (cand_x_q == apple_x_q && cand_y_q == apple_y_q);

    // A body hit kills the read issued in the same cycle, so the scan stops at the hit.
    assign seg_hit = cmp_valid_q && (seg_rd_x == cand_x_q) && (seg_rd_y == cand_y_q);
    assign rd_last = ({1'b0, rd_addr_q} == (len_q - 7'd1));

    assign tries_inc    = (tries_q == TRY_LIM) ? tries_q : tries_q + 8'd1;
    assign reject_limit = (tries_inc == TRY_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            lfsr_q      <= SEED;
            tries_q     <= 8'd0;
            level_q     <= 2'd0;
            len_q       <= 7'd0;
            cand_x_q    <= 6'd0;
            cand_y_q    <= 5'd0;
            apple_x_q   <= 6'd20;
            apple_y_q   <= 5'd10;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= 6'd0;
            cmp_valid_q <= 1'b0;
            cmp_last_q  <= 1'b0;
        end else begin
            lfsr_q <= lfsr_d;
            done_q <= 1'b0;
            fail_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (place_req) begin
                        level_q <= level;
                        len_q   <= (snake_len > LEN_LIM) ? LEN_LIM : snake_len;
                        tries_q <= 8'd0;
                        busy_q  <= 1'b1;
                        state_q <= S_DRAW;
                    end
                end
                S_DRAW: begin
                    cand_x_q <= lfsr_q[15:10];
                    cand_y_q <= lfsr_q[4:0];
                    state_q  <= S_CHECK;
                end
                S_CHECK: begin
                    if (cand_bad) begin
                        tries_q <= tries_inc;
                        state_q <= reject_limit ? S_FAIL : S_DRAW;
                    end else if (len_q != 7'd0) begin
                        rd_en_q     <= 1'b1;
                        rd_addr_q   <= 6'd0;
                        cmp_valid_q <= 1'b0;
                        cmp_last_q  <= 1'b0;
                        state_q     <= S_SCAN;
                    end else begin
                        state_q <= S_COMMIT;
                    end
                end
                S_SCAN: begin
                    cmp_valid_q <= seg_rd_en;
                    cmp_last_q  <= rd_last;
                    if (seg_hit) begin
                        rd_en_q     <= 1'b0;
                        cmp_valid_q <= 1'b0;
                        tries_q     <= tries_inc;
                        state_q     <= reject_limit ? S_FAIL : S_DRAW;
                    end else if (cmp_valid_q && cmp_last_q) begin
                        state_q <= S_COMMIT;
                    end else if (rd_en_q) begin
                        if (rd_last) begin
                            rd_en_q <= 1'b0;
                        end else begin
                            rd_addr_q <= rd_addr_q + 6'd1;
                        end
                    end
                end
                S_COMMIT: begin
                    apple_x_q <= cand_x_q;
                    apple_y_q <= cand_y_q;
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
                S_FAIL: begin
                    done_q  <= 1'b1;
                    fail_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    rd_en_q <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign place_busy  = busy_q;
    assign place_done  = done_q;
    assign place_fail  = fail_q;
    assign seg_rd_en   = rd_en_q && !seg_hit;
    assign seg_rd_addr = rd_addr_q;
    assign apple_x     = apple_x_q;
    assign apple_y     = apple_y_q;

endmodule

// File: tb/tb_apple_place_ctrl.sv
// Directed bench for apple_place_ctrl: a reference LFSR picks request times that
// yield the wanted candidates; a behavioural placement model gives expected results.
module tb_apple_place_ctrl;

    localparam int          MAX_TRIES = 4;
    localparam logic [15:0] SEED      = 16'hACE1;

    logic       clk;
    logic       rst_n;
    logic [1:0] level;
    logic [6:0] snake_len;
    logic       place_req;
    logic       place_busy;
    logic       place_done;
    logic       place_fail;
    logic       seg_rd_en;
    logic [5:0] seg_rd_addr;
    logic [5:0] seg_rd_x;
    logic [4:0] seg_rd_y;
    logic [5:0] apple_x;
    logic [4:0] apple_y;

    apple_place_ctrl #(.MAX_TRIES(MAX_TRIES)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .level       (level),
        .snake_len   (snake_len),
        .place_req   (place_req),
        .place_busy  (place_busy),
        .place_done  (place_done),
        .place_fail  (place_fail),
        .seg_rd_en   (seg_rd_en),
        .seg_rd_addr (seg_rd_addr),
        .seg_rd_x    (seg_rd_x),
        .seg_rd_y    (seg_rd_y),
        .apple_x     (apple_x),
        .apple_y     (apple_y)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic logic [15:0] lstep(input logic [15:0] v);
        if (v == 16'h0000) return SEED;
        if (v[0]) return (v >> 1) ^ 16'hB400;
        return v >> 1;
    endfunction

    // Reference LFSR plus two cycles of history, reset together with the DUT
    logic [15:0] mdl_lfsr, hist1, hist2;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_lfsr <= SEED;
            hist1    <= SEED;
            hist2    <= SEED;
        end else begin
            hist2    <= hist1;
            hist1    <= mdl_lfsr;
            mdl_lfsr <= lstep(mdl_lfsr);
        end
    end

    // Body RAM; in all_mode the first scan read returns the cell drawn two cycles earlier
    logic [5:0] body_x [64];
    logic [4:0] body_y [64];
    bit         all_mode = 1'b0;
    always @(posedge clk) begin
        if (seg_rd_en) begin
            if (all_mode) begin
                seg_rd_x <= hist2[15:10];
                seg_rd_y <= hist2[4:0];
            end else begin
                seg_rd_x <= body_x[seg_rd_addr];
                seg_rd_y <= body_y[seg_rd_addr];
            end
        end
    end

    int cur_level = 0;
    int cur_len   = 0;
    int apple_ex  = 20;
    int apple_ey  = 10;
    bit inject    = 1'b0;
    int rd_cnt, rd_last;

    function automatic bit is_obst(input int lv, input int x, input int y);
        bit col, bar;
        col = ((x == 12 || x == 24) && y >= 4 && y <= 10) ||
              ((x == 16 || x == 28) && y >= 18 && y <= 26);
        bar = (y == 10 || y == 20) && ((x >= 5 && x <= 8) || (x >= 32 && x <= 35));
        return ((lv == 1 || lv == 2) && col) || (lv == 2 && bar);
    endfunction

    // Walk the placement procedure from the LFSR value seen in the first DRAW cycle
    function automatic void predict(input logic [15:0] l1, output bit p_fail, output int p_x,
                                    output int p_y, output int p_tries, output int p_done);
        logic [15:0] l;
        int pos, t, cx, cy, m, d;
        l = l1; pos = 1; t = 0;
        p_fail = 1'b0; p_x = apple_ex; p_y = apple_ey; p_tries = 0; p_done = 0;
        for (int guard = 0; guard < 300; guard++) begin
            cx = int'(l[15:10]);
            cy = int'(l[4:0]);
            if (cx == 0 || cx > 38 || cy == 0 || cy > 28 || is_obst(cur_level, cx, cy) ||
                (cx == apple_ex && cy == apple_ey)) begin
                d = 2;
            end else begin
                m = -1;
                if (all_mode && cur_len > 0) m = 0;
                else for (int i = 0; i < cur_len; i++)
                    if (m < 0 && int'(body_x[i]) == cx && int'(body_y[i]) == cy) m = i;
                if (m < 0) begin
                    p_x = cx; p_y = cy; p_tries = t;
                    p_done = (cur_len == 0) ? pos + 3 : pos + cur_len + 4;
                    return;
                end
                d = m + 4;
            end
            t++;
            if (t == MAX_TRIES) begin
                p_fail = 1'b1; p_tries = t; p_done = pos + d + 1;
                return;
            end
            for (int k = 0; k < d; k++) l = lstep(l);
            pos += d;
        end
    endfunction

    // Advance cycle by cycle until a request issued now would exercise the wanted case
    task automatic find_start(input int crit, output bit ok);
        logic [15:0] l1;
        bit pf, good;
        int px, py, pt, pd, cx, cy;
        ok = 1'b0;
        for (int n = 0; n < 20000 && !ok; n++) begin
            @(posedge clk); #1;
            l1 = lstep(mdl_lfsr);
            cx = int'(l1[15:10]);
            cy = int'(l1[4:0]);
            if (crit == 2) begin
                body_x[0] = 6'(cx - 1); body_y[0] = 5'(cy);
                body_x[1] = 6'(cx);     body_y[1] = 5'(cy);
                body_x[2] = 6'(cx + 1); body_y[2] = 5'(cy);
            end
            predict(l1, pf, px, py, pt, pd);
            case (crit)
                0:       good = !pf && pt == 0;
                1:       good = !pf && pt == 1 && is_obst(1, cx, cy);
                2:       good = !pf && pt == 1 && cx >= 2 && cx <= 37 && cy >= 1 && cy <= 28 &&
                                !(cx == apple_ex && cy == apple_ey);
                default: good = 1'b1;
            endcase
            if (good) ok = 1'b1;
        end
    endtask

    // Issue a request in the current cycle and check the whole transaction
    task automatic run_req(input string nm);
        bit p_fail, moved, seen, ended;
        int p_x, p_y, p_tries, p_done, cyc;
        predict(lstep(mdl_lfsr), p_fail, p_x, p_y, p_tries, p_done);
        level     = 2'(cur_level);
        snake_len = 7'(cur_len);
        place_req = 1'b1;
        @(posedge clk); #1;
        place_req = 1'b0;
        cyc = 1; moved = 1'b0; seen = 1'b0; ended = 1'b0; rd_cnt = 0; rd_last = -1;
        check({nm, "_busy"}, place_busy, 1);
        while (cyc < 2000 && !place_done) begin
            if (int'(apple_x) != apple_ex || int'(apple_y) != apple_ey) moved = 1'b1;
            if (seg_rd_en && !ended) begin
                rd_cnt++; rd_last = int'(seg_rd_addr); seen = 1'b1;
            end else if (seen) begin
                ended = 1'b1;
            end
            place_req = inject && (cyc == 10);
            @(posedge clk); #1;
            cyc++;
        end
        place_req = 1'b0;
        $display("req %s: apple=(%0d,%0d) fail=%0d tries=%0d latency=%0d", nm, apple_x, apple_y,
                 place_fail, dut.tries_q, cyc);
        check({nm, "_done"}, place_done, 1);
        check({nm, "_latency"}, cyc, p_done);
        check({nm, "_fail"}, place_fail, p_fail);
        check({nm, "_apple_x"}, apple_x, p_x);
        check({nm, "_apple_y"}, apple_y, p_y);
        check({nm, "_apple_hold"}, moved, 0);
        check({nm, "_tries"}, dut.tries_q, p_tries);
        @(posedge clk); #1;
        check({nm, "_done_pulse"}, place_done, 0);
        check({nm, "_busy_off"}, place_busy, 0);
        apple_ex = p_x;
        apple_ey = p_y;
    endtask

    initial begin
        bit ok;
        int dones;
        rst_n = 1'b0; level = 2'd0; snake_len = 7'd0; place_req = 1'b0;
        for (int i = 0; i < 64; i++) begin
            body_x[i] = 6'd0;
            body_y[i] = 5'd0;
        end

        // T1: reset values
        repeat (3) @(posedge clk); #1;
        check("rst_apple_x", apple_x, 20);
        check("rst_apple_y", apple_y, 10);
        check("rst_busy", place_busy, 0);
        check("rst_done", place_done, 0);
        check("rst_fail", place_fail, 0);
        check("rst_rd_en", seg_rd_en, 0);
        check("rst_rd_addr", seg_rd_addr, 0);
        check("rst_lfsr", dut.lfsr_q, 16'hACE1);
        rst_n = 1'b1;
        repeat (5) @(posedge clk); #1;
        check("lfsr_run", dut.lfsr_q, mdl_lfsr);

        // T2: empty body, no obstacles, first candidate accepted
        cur_level = 0; cur_len = 0;
        find_start(0, ok);
        if (ok) run_req("t2"); else check("t2_search", 0, 1);

        // T3: first candidate lands on a level-1 column, second accepted
        cur_level = 1; cur_len = 0;
        find_start(1, ok);
        if (ok) run_req("t3"); else check("t3_search", 0, 1);

        // T4: body of three cells around the first candidate; hit at address 1
        cur_level = 0; cur_len = 3;
        find_start(2, ok);
        if (ok) begin
            run_req("t4");
            check("t4_scan_reads", rd_cnt, 2);
            check("t4_scan_last_addr", rd_last, 1);
        end else begin
            check("t4_search", 0, 1);
        end
        for (int i = 0; i < 64; i++) begin
            body_x[i] = 6'd0;
            body_y[i] = 5'd0;
        end

        // T5: every scanned cell is occupied -> MAX_TRIES rejects, done with fail
        cur_level = 0; cur_len = 5; all_mode = 1'b1;
        @(posedge clk); #1;
        run_req("t5");
        all_mode = 1'b0;

        // T6a: full-length scan with no hits, a stray request mid-scan is ignored
        cur_level = 2; cur_len = 64; inject = 1'b1;
        @(posedge clk); #1;
        run_req("t6a");
        inject = 1'b0;
        check("t6a_lfsr", dut.lfsr_q, mdl_lfsr);

        // T6b: reset during a scan aborts the request without a done pulse
        level = 2'd0; snake_len = 7'd64; place_req = 1'b1;
        @(posedge clk); #1;
        place_req = 1'b0;
        repeat (8) @(posedge clk); #1;
        check("t6b_busy_before", place_busy, 1);
        rst_n = 1'b0;
        #1;
        check("t6b_busy_rst", place_busy, 0);
        check("t6b_rd_en_rst", seg_rd_en, 0);
        check("t6b_apple_x", apple_x, 20);
        check("t6b_apple_y", apple_y, 10);
        @(posedge clk); #1;
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (place_done) dones++;
        end
        $display("req t6b: reset mid-scan, done pulses afterwards=%0d", dones);
        check("t6b_no_done", dones, 0);
        check("t6b_lfsr", dut.lfsr_q, mdl_lfsr);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
